// File: rtl/quant_pipeline_mc.sv
// Multi-channel adaptive quantizer: per-channel frame peak drives a shift, samples are
// quantized, rescaled and queued in an output FIFO. Optional macro: QUANT_SAT_COUNT_EN.
module quant_pipeline_mc #(
    parameter int DATA_W     = 32,
    parameter int QUANT_W    = 8,
    parameter int CHANNELS   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic                                                syncTo10ms,
    input  logic [DATA_W-1:0]                                   inData,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] inChannel,
    input  logic                                                inValid,
    output logic                                                inReady,
    output logic [DATA_W-1:0]                                   outData,
    output logic [QUANT_W-1:0]                                  outQuant,
    output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] outChannel,
    output logic                                                outUser,
    output logic                                                outValid,
    input  logic                                                outReady
`ifdef QUANT_SAT_COUNT_EN
    ,
    output logic [15:0]                                         satCount
`endif
);
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int SH_W  = $clog2(DATA_W);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = DATA_W + QUANT_W + CH_W + 1;

    logic [DATA_W-2:0]  peakAcc_q [CHANNELS];
    logic [SH_W-1:0]    exp_q [CHANNELS];
    logic [CHANNELS-1:0] firstFlag_q;
    logic               inReady_q;

    logic               s1Valid_q, s1User_q;
    logic [DATA_W-1:0]  s1Data_q;
    logic [CH_W-1:0]    s1Chan_q;
    logic [SH_W-1:0]    s1Shift_q;

    logic               s2Valid_q, s2User_q;
    logic [DATA_W-1:0]  s2Data_q;
    logic [QUANT_W-1:0] s2Quant_q;
    logic [CH_W-1:0]    s2Chan_q;

    logic [ENT_W-1:0]   fifoMem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wrPtr_q, rdPtr_q;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               accept, chanOk, s1Valid_d, s2Valid_d, push, pop;
    logic [DATA_W-1:0]  negIn;
    logic [DATA_W-2:0]  absIn;
    logic [SH_W-1:0]    expEff, inShift;
    int                 shiftInt, occNext;
    logic signed [DATA_W-1:0] qFull;
    logic [DATA_W-QUANT_W:0]  upper;
    logic               sat;
    logic [QUANT_W-1:0] qSat;
    logic [DATA_W-1:0]  rescaled;

    function automatic logic [SH_W-1:0] msbIndex(input logic [DATA_W-2:0] v);
        msbIndex = '0;
        for (int i = 0; i < DATA_W - 1; i++) begin
            if (v[i]) msbIndex = SH_W'(i);
        end
    endfunction

    // Input side: magnitude and shift; a sync in the same cycle bypasses the stored exponent
    always_comb begin
        accept   = inValid && inReady_q;
        chanOk   = int'(inChannel) < CHANNELS;
        negIn    = -inData;
        absIn    = inData[DATA_W-1] ? (negIn[DATA_W-1] ? '1 : negIn[DATA_W-2:0])
                                    : inData[DATA_W-2:0];
        expEff   = syncTo10ms ? msbIndex(peakAcc_q[inChannel]) : exp_q[inChannel];
        shiftInt = int'(expEff) + 2 - QUANT_W;
        inShift  = (shiftInt > 0) ? SH_W'(shiftInt) : '0;
    end

    always_comb begin
        qFull    = $signed(s1Data_q) >>> s1Shift_q;
        upper    = qFull[DATA_W-1:QUANT_W-1];
        sat      = !((&upper) || !(|upper));
        qSat     = qFull[QUANT_W-1:0];
        if (sat) qSat = qFull[DATA_W-1] ? {1'b1, {(QUANT_W-1){1'b0}}}
                                        : {1'b0, {(QUANT_W-1){1'b1}}};
        rescaled = {{(DATA_W-QUANT_W){qSat[QUANT_W-1]}}, qSat} << s1Shift_q;
    end

    // Credit count covers every sample already inside the pipe, so the FIFO never overflows
    always_comb begin
        s1Valid_d = accept && chanOk;
        s2Valid_d = s1Valid_q;
        push      = s2Valid_q;
        pop       = outValid && outReady;
        count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
        occNext   = int'(count_d) + int'(s1Valid_d) + int'(s2Valid_d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                peakAcc_q[c] <= '0;
                exp_q[c]     <= SH_W'(DATA_W - 2);
            end
            firstFlag_q <= '1;
            inReady_q   <= 1'b0;
        end else begin
            inReady_q <= occNext < FIFO_DEPTH;
            if (syncTo10ms) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    exp_q[c]     <= msbIndex(peakAcc_q[c]);
                    peakAcc_q[c] <= '0;
                end
                firstFlag_q <= '1;
            end
            if (accept && chanOk) begin
                if (syncTo10ms || absIn > peakAcc_q[inChannel]) peakAcc_q[inChannel] <= absIn;
                firstFlag_q[inChannel] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1Valid_q <= 1'b0;
            s1User_q  <= 1'b0;
            s1Data_q  <= '0;
            s1Chan_q  <= '0;
            s1Shift_q <= '0;
            s2Valid_q <= 1'b0;
            s2User_q  <= 1'b0;
            s2Data_q  <= '0;
            s2Quant_q <= '0;
            s2Chan_q  <= '0;
        end else begin
            s1Valid_q <= s1Valid_d;
            if (s1Valid_d) begin
                s1Data_q  <= inData;
                s1Chan_q  <= inChannel;
                s1Shift_q <= inShift;
                s1User_q  <= syncTo10ms || firstFlag_q[inChannel];
            end
            s2Valid_q <= s2Valid_d;
            if (s2Valid_d) begin
                s2Data_q  <= rescaled;
                s2Quant_q <= qSat;
                s2Chan_q  <= s1Chan_q;
                s2User_q  <= s1User_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) fifoMem_q[i] <= '0;
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                fifoMem_q[wrPtr_q] <= {s2Data_q, s2Quant_q, s2Chan_q, s2User_q};
                wrPtr_q            <= wrPtr_q + PTR_W'(1);
            end
            if (pop) rdPtr_q <= rdPtr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    assign inReady  = inReady_q;
    assign outValid = count_q != '0;
    assign {outData, outQuant, outChannel, outUser} = fifoMem_q[rdPtr_q];

`ifdef QUANT_SAT_COUNT_EN
    logic [15:0] satCount_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            satCount_q <= '0;
        end else if (s1Valid_q && sat && satCount_q != 16'hFFFF) begin
            satCount_q <= satCount_q + 16'd1;
        end
    end

    assign satCount = satCount_q;
`endif

endmodule

// File: tb/tb_quant_pipeline_mc.sv
// Self-checking bench for quant_pipeline_mc: constant vector table, hand-written corner
// sequences and randomized traffic checked against a frame-level reference model.
module tb_quant_pipeline_mc;
    logic        clk = 1'b0;
    logic        rst;
    logic        syncTo10ms;
    logic [31:0] inData;
    logic [1:0]  inChannel;
    logic        inValid;
    logic        inReady;
    logic [31:0] outData;
    logic [7:0]  outQuant;
    logic [1:0]  outChannel;
    logic        outUser;
    logic        outValid;
    logic        outReady;
`ifdef QUANT_SAT_COUNT_EN
    logic [15:0] satCount;
`endif

    quant_pipeline_mc dut (
        .clk(clk), .rst(rst), .syncTo10ms(syncTo10ms),
        .inData(inData), .inChannel(inChannel), .inValid(inValid), .inReady(inReady),
        .outData(outData), .outQuant(outQuant), .outChannel(outChannel),
        .outUser(outUser), .outValid(outValid), .outReady(outReady)
`ifdef QUANT_SAT_COUNT_EN
        , .satCount(satCount)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  quant;
        logic [1:0]  ch;
        logic        user;
    } out_t;

    typedef struct {
        int          ch;
        logic [31:0] din;
        bit          syncFirst;
        logic [7:0]  q;
        logic [31:0] d;
        bit          user;
    } vec_t;

    out_t   expQ[$];
    out_t   gotQ[$];
    longint mPeak[4];
    int     mExp[4];
    bit     mFirst[4];
    int     mSat;
    int     checks = 0;
    int     errors = 0;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Reference model: whole-frame peak bookkeeping and arithmetic quantization
    task automatic modelReset();
        expQ.delete();
        for (int c = 0; c < 4; c++) begin
            mPeak[c] = 0; mExp[c] = 30; mFirst[c] = 1'b1;
        end
        mSat = 0;
    endtask

    task automatic modelFrame();
        for (int c = 0; c < 4; c++) begin
            longint p = mPeak[c];
            int e = 0;
            while (p > 1) begin p = p / 2; e++; end
            mExp[c] = e; mPeak[c] = 0; mFirst[c] = 1'b1;
        end
    endtask

    task automatic modelAccept(input logic [31:0] x, input logic [1:0] ch);
        longint sx, a, q;
        int s;
        out_t e;
        sx = longint'($signed(x));
        a  = (sx < 0) ? -sx : sx;
        if (a > 64'sd2147483647) a = 64'sd2147483647;
        if (a > mPeak[ch]) mPeak[ch] = a;
        s = mExp[ch] + 2 - 8;
        if (s < 0) s = 0;
        q = sx >>> s;
        if (q > 127)  begin q = 127;  if (mSat < 65535) mSat++; end
        if (q < -128) begin q = -128; if (mSat < 65535) mSat++; end
        e.data  = 32'(q <<< s);
        e.quant = 8'(q);
        e.ch    = ch;
        e.user  = mFirst[ch];
        mFirst[ch] = 1'b0;
        expQ.push_back(e);
    endtask

    always @(negedge clk) begin
        out_t g, e;
        if (!rst) begin
            modelReset();
        end else begin
            if (outValid && outReady) begin
                g = {outData, outQuant, outChannel, outUser};
                gotQ.push_back(g);
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpectedOutput: got d=%h q=%h with no pending sample", outData, outQuant);
                end else begin
                    e = expQ.pop_front();
                    if (g !== e) begin
                        errors++;
                        $display("[TB] FAIL scoreboard: got d=%h q=%h ch=%0d u=%0d, expected d=%h q=%h ch=%0d u=%0d",
                                 g.data, g.quant, g.ch, g.user, e.data, e.quant, e.ch, e.user);
                    end
                end
            end
            if (syncTo10ms) modelFrame();
            if (inValid && inReady) modelAccept(inData, inChannel);
        end
    end

    task automatic applyStimulus(input int ch, input logic [31:0] d, input bit sync);
        bit done = 1'b0;
        inChannel = 2'(ch); inData = d; inValid = 1'b1; syncTo10ms = sync;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk); done = inReady;
            @(posedge clk); #1; syncTo10ms = 1'b0;
        end
        inValid = 1'b0;
        if (!done) checkOutput("acceptTimeout", 0, 1);
    endtask

    task automatic pulseSync();
        syncTo10ms = 1'b1;
        @(posedge clk); #1;
        syncTo10ms = 1'b0;
    endtask

    task automatic waitGot(input int n);
        for (int i = 0; i < 60 && gotQ.size() < n; i++) @(posedge clk);
        #1;
        checkOutput("waitOutput", 64'(gotQ.size() >= n), 1);
    endtask

    task automatic checkOne(input string name, input logic [7:0] q, input logic [31:0] d,
                            input int ch, input bit user);
        out_t g;
        if (gotQ.size() == 0) begin
            checkOutput({name, "_missing"}, 0, 1);
        end else begin
            g = gotQ.pop_front();
            checkOutput({name, "_quant"}, g.quant, q);
            checkOutput({name, "_data"}, g.data, d);
            checkOutput({name, "_ch"}, g.ch, 64'(ch));
            checkOutput({name, "_user"}, g.user, 64'(user));
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t vecs[9];
        logic [31:0] bpData[10];
        logic [31:0] held;
        int acc, seen;

        vecs[0] = '{1, 32'd1000,       1'b0, 8'h00, 32'h0000_0000, 1'b1};
        vecs[1] = '{1, 32'd1000,       1'b1, 8'h7D, 32'h0000_03E8, 1'b1};
        vecs[2] = '{1, 32'd999,        1'b0, 8'h7C, 32'h0000_03E0, 1'b0};
        vecs[3] = '{1, 32'hFFFF_FC18,  1'b0, 8'h83, 32'hFFFF_FC18, 1'b0};
        vecs[4] = '{1, 32'd5000,       1'b0, 8'h7F, 32'h0000_03F8, 1'b0};
        vecs[5] = '{1, 32'hFFFF_EC78,  1'b0, 8'h80, 32'hFFFF_FC00, 1'b0};
        vecs[6] = '{3, 32'd100,        1'b0, 8'h64, 32'h0000_0064, 1'b1};
        vecs[7] = '{3, 32'hFFFF_FF38,  1'b0, 8'h80, 32'hFFFF_FF80, 1'b0};
        vecs[8] = '{0, 32'h8000_0000,  1'b0, 8'h80, 32'h8000_0000, 1'b1};

        rst = 1'b0; syncTo10ms = 1'b0; inData = 32'hDEAD_BEEF; inChannel = 2'd0;
        inValid = 1'b1; outReady = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rstOutValid", outValid, 0);
        checkOutput("rstOutData", outData, 0);
        checkOutput("rstOutQuant", outQuant, 0);
        checkOutput("rstOutMeta", {outChannel, outUser}, 0);
        checkOutput("rstInReady", inReady, 0);
`ifdef QUANT_SAT_COUNT_EN
        checkOutput("rstSatCount", satCount, 0);
`endif
        @(posedge clk); #1;
        inValid = 1'b0; rst = 1'b1;
        #1 checkOutput("inReadyBeforeEdge", inReady, 0);
        @(posedge clk); #1;
        checkOutput("inReadyAfterEdge", inReady, 1);

        gotQ.delete();
        applyStimulus(0, 32'h4000_0000, 1'b0);
        checkOutput("latencyN1", outValid, 0);
        @(posedge clk); #1;
        checkOutput("latencyN2", outValid, 0);
        @(posedge clk); #1;
        checkOutput("latencyN3", outValid, 1);
        waitGot(1);
        checkOne("fullScale", 8'h40, 32'h4000_0000, 0, 1'b1);

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].syncFirst) pulseSync();
            gotQ.delete();
            applyStimulus(vecs[i].ch, vecs[i].din, 1'b0);
            waitGot(1);
            checkOne($sformatf("vec%0d", i), vecs[i].q, vecs[i].d, vecs[i].ch, vecs[i].user);
        end
`ifdef QUANT_SAT_COUNT_EN
        repeat (3) @(posedge clk); #1;
        checkOutput("satCountTable", satCount, 3);
`endif

        gotQ.delete();
        applyStimulus(2, 32'd40, 1'b0);
        applyStimulus(2, 32'd300, 1'b1);
        pulseSync();
        applyStimulus(2, 32'd256, 1'b0);
        waitGot(3);
        checkOne("syncSeed", 8'd40, 32'd40, 2, 1'b1);
        checkOne("syncCollide", 8'h7F, 32'h7F, 2, 1'b1);
        checkOne("nextFrameExp", 8'h40, 32'd256, 2, 1'b1);

        repeat (5) @(posedge clk); #1;
        gotQ.delete();
        outReady = 1'b0; acc = 0;
        for (int i = 0; i < 10; i++) bpData[i] = $urandom;
        inValid = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            inChannel = 2'(acc); inData = bpData[acc];
            @(negedge clk); if (inReady) acc++;
            @(posedge clk); #1;
        end
        checkOutput("bpAccepted", acc, 4);
        checkOutput("bpReadyLow", inReady, 0);
        held = outData;
        repeat (3) @(posedge clk); #1;
        checkOutput("bpStable", outData, held);
        checkOutput("bpValidHeld", outValid, 1);
        outReady = 1'b1;
        for (int cyc = 0; cyc < 60 && acc < 10; cyc++) begin
            inChannel = 2'(acc); inData = bpData[acc];
            @(negedge clk); if (inReady) acc++;
            @(posedge clk); #1;
        end
        inValid = 1'b0;
        waitGot(10);
        checkOutput("bpCount", gotQ.size(), 10);
        for (int i = 0; i < 10 && i < gotQ.size(); i++)
            checkOutput($sformatf("bpOrder%0d", i), gotQ[i].ch, 64'(i % 4));

        for (int cyc = 0; cyc < 400; cyc++) begin
            logic [31:0] r;
            r = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) r = -r;
            if ($urandom_range(0, 40) == 0) r = 32'h8000_0000;
            inData     = r;
            inChannel  = 2'($urandom_range(0, 3));
            inValid    = ($urandom_range(0, 3) != 0);
            outReady   = ($urandom_range(0, 3) != 0);
            syncTo10ms = ($urandom_range(0, 39) == 0);
            @(posedge clk); #1;
        end
        inValid = 1'b0; syncTo10ms = 1'b0; outReady = 1'b1;
        for (int i = 0; i < 60 && (expQ.size() != 0 || outValid); i++) begin
            @(posedge clk); #1;
        end
        checkOutput("drainEmpty", expQ.size(), 0);
        checkOutput("drainIdle", outValid, 0);
`ifdef QUANT_SAT_COUNT_EN
        checkOutput("satCountRandom", satCount, 64'(mSat));
`endif

        outReady = 1'b0; inValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            inChannel = 2'(i); inData = $urandom;
            @(posedge clk); #1;
        end
        #1 rst = 1'b0;
        #1;
        checkOutput("midRstValid", outValid, 0);
        checkOutput("midRstReady", inReady, 0);
        checkOutput("midRstData", {outData, outQuant}, 0);
        inValid = 1'b0;
        @(posedge clk); @(posedge clk); #3;
        rst = 1'b1; outReady = 1'b1;
        checkOutput("midRelReady", inReady, 0);
        @(posedge clk); #1;
        checkOutput("midRelReadyEdge", inReady, 1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); if (outValid) seen++;
        end
        checkOutput("midRstFlushed", seen, 0);
        @(posedge clk); #1;
        gotQ.delete();
        applyStimulus(0, 32'h4000_0000, 1'b0);
        waitGot(1);
        checkOne("postReset", 8'h40, 32'h4000_0000, 0, 1'b1);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule

// File: doc/quant_pipeline_mc.md
Name: quant_pipeline_mc

Overview:
- Multi-channel successor to the scaler/quantizer/rescaler chain.
- Per channel, tracks the peak magnitude over each 10 ms frame (frames delimited by syncTo10ms).
- Each sample is quantized to QUANT_W bits using a shift derived from the channel's previous-frame peak, then rescaled back to DATA_W.
- Full valid/ready handshake on input and output, with an output FIFO for backpressure. Replaces the fixed-width, always-ready top-level pipeline.

Parameters:
- DATA_W, 32, input/output sample width (signed two's complement).
- QUANT_W, 8, quantized width (signed), 2 <= QUANT_W < DATA_W.
- CHANNELS, 4, number of interleaved channels. Local CH_W = max(1, clog2(CHANNELS)).
- FIFO_DEPTH, 4, output FIFO entries (power of 2, >= 4).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- syncTo10ms  in  1  single-cycle frame-boundary pulse.
- inData  in  DATA_W  input sample.
- inChannel  in  CH_W  channel id of inData; values >= CHANNELS are dropped (accepted, no output).
- inValid  in  1  input valid.
- inReady  out  1  input ready.
- outData  out  DATA_W  rescaled sample.
- outQuant  out  QUANT_W  quantized code.
- outChannel  out  CH_W  channel id.
- outUser  out  1  first output sample of its channel in the current frame.
- outValid  out  1  output valid.
- outReady  in  1  output ready.

Behaviour:
- Reset (rst=0, async):
  - All outputs 0; inReady 0; FIFO emptied; pipeline valids cleared.
  - peakAcc[c]=0; exp[c]=DATA_W-2; firstFlag[c]=1.
  - Reset asserted mid-transfer discards all in-flight data. inReady rises on the first clk edge after release.
- Accept: a sample is accepted when inValid && inReady.
  - inReady = (fifoCount + stage1Valid + stage2Valid) < FIFO_DEPTH (credit scheme; no sample is ever dropped).
  - inReady is registered.
- Pipeline:
  - S1 registers the sample, channel and shift s.
  - S2 registers q, rescaled data and user flag.
  - S2 then writes the FIFO; the FIFO output is registered.
  - Latency: acceptance at cycle N gives outValid at N+3 when the FIFO is empty.
  - Throughput: 1 sample/cycle when outReady=1.
- Peak tracking:
  - abs(x) for accepted samples; abs(-2^(DATA_W-1)) saturates to 2^(DATA_W-1)-1.
  - peakAcc[c] <= max(peakAcc[c], abs(x)).
- Frame boundary (syncTo10ms=1):
  - For every c: exp[c] <= msb_index(peakAcc[c]) (0 if peak=0); peakAcc[c] <= 0; firstFlag[c] <= 1.
  - A sample accepted in the sync cycle belongs to the new frame: it is quantized with the newly computed exp (combinational bypass) and seeds peakAcc with abs(x).
- Shift: s = max(0, exp[c] + 2 - QUANT_W).
- Quantize:
  - q = x >>> s (arithmetic).
  - Saturate q to [-2^(QUANT_W-1), 2^(QUANT_W-1)-1].
- Rescale: outData = sign_extend(q) << s. Bits below s are zero.
- outUser: 1 on the sample that clears firstFlag[channel]; the flag clears when that sample enters S1.
- Output handshake:
  - FIFO pops on outValid && outReady.
  - outData/outQuant/outChannel/outUser stay stable while outValid && !outReady.
  - Simultaneous push and pop at full or empty is legal; count is unchanged.

Optional Feature:
- Macro QUANT_SAT_COUNT_EN.
- Defined: adds port satCount out 16, a count of saturated samples. It saturates at 0xFFFF, is cleared only by reset, and updates in S2.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset: hold rst=0 with inValid=1 -> all outputs 0 and inReady=0. After release, inReady=1 at the next edge.
- Pre-sync full scale: ch0 inData=0x4000_0000 -> s=24, outQuant=0x40, outData=0x4000_0000, outUser=1, outValid 3 cycles after accept.
- Adaptive: ch1 peak 1000 in a frame, then sync. Send 1000/999/-1000 -> s=3; outQuant=125/124/-125; outData=1000/992/-1000; outUser=1 only on the first.
- Saturation: same frame, inputs 5000 and -5000 -> outQuant=127/-128, outData=1016/-1024. satCount=2 when QUANT_SAT_COUNT_EN is defined.
- Backpressure: outReady=0 with 10 samples offered -> exactly 4 accepted, then inReady=0. Release outReady -> 10 outputs in order, no loss or duplication.
- Sync collision: ch2 sample of 300 accepted in the sync cycle, previous-frame peak 40 (msb 5) -> s=0, outQuant clipped to 127. The next frame's exp derives from peak 300 (exp=8).
